// File: rtl/i_decode.sv
// Instruction-decode stage: 32x32 register file, control decode, immediate
// sign-extension, load-use hazard detection and the registered ID/EX boundary.
// Optional build macro: ID_WB_BYPASS_EN -- when defined, a writeback to the
// register being read in the same cycle is forwarded to the read port.
module i_decode #(
  parameter int DATA_W = 32,
  parameter int NREGS  = 32
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [31:0]       IF_ID_INSTR,
  input  logic [31:0]       IF_ID_NPC,
  input  logic              EX_MEM_PCSrc,
  input  logic              MEM_WB_RegWrite,
  input  logic [4:0]        MEM_WB_WriteReg,
  input  logic [DATA_W-1:0] MEM_WB_WriteData,
  output logic              STALL,
  output logic [31:0]       ID_EX_NPC,
  output logic [DATA_W-1:0] ID_EX_A,
  output logic [DATA_W-1:0] ID_EX_B,
  output logic [DATA_W-1:0] ID_EX_IMM,
  output logic [4:0]        ID_EX_RT,
  output logic [4:0]        ID_EX_RD,
  output logic [5:0]        ID_EX_FUNCT,
  output logic [6:0]        ID_EX_CTRL
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;

  // Control word layout: {RegWrite,MemRead,MemWrite,ALUSrc,RegDst,Branch,Valid}
  localparam int CTRL_MEMREAD = 5;
  localparam int CTRL_VALID   = 0;

  logic [DATA_W-1:0] regs [NREGS];

  logic [5:0] op;
  logic [4:0] rs, rt, rd;
  logic [6:0] ctrl_dec;
  logic       rt_src;
  logic [DATA_W-1:0] a_rd, b_rd;
  logic       load_p0;

  assign op = IF_ID_INSTR[31:26];
  assign rs = IF_ID_INSTR[25:21];
  assign rt = IF_ID_INSTR[20:16];
  assign rd = IF_ID_INSTR[15:11];

  function automatic logic [DATA_W-1:0] sext16(input logic [15:0] imm);
    sext16 = {{(DATA_W-16){imm[15]}}, imm};
  endfunction

  // Register file write port; index 0 is hard-wired to zero and never written.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (MEM_WB_RegWrite && (MEM_WB_WriteReg != 5'd0)) begin
      regs[MEM_WB_WriteReg] <= MEM_WB_WriteData;
    end
  end

  // Combinational read ports, with optional same-cycle writeback forwarding.
  always_comb begin
    a_rd = regs[rs];
    b_rd = regs[rt];
`ifdef ID_WB_BYPASS_EN
    if (MEM_WB_RegWrite && (MEM_WB_WriteReg != 5'd0) && (MEM_WB_WriteReg == rs))
      a_rd = MEM_WB_WriteData;
    if (MEM_WB_RegWrite && (MEM_WB_WriteReg != 5'd0) && (MEM_WB_WriteReg == rt))
      b_rd = MEM_WB_WriteData;
`else
    // Without forwarding the read sees the pre-write contents.
`endif
    if (rs == 5'd0) a_rd = '0;
    if (rt == 5'd0) b_rd = '0;
  end

  // Opcode decode; rt_src marks formats whose rt field is a source operand.
  always_comb begin
    ctrl_dec = 7'b0000000;
    rt_src   = 1'b0;
    case (op)
      OP_RTYPE: begin ctrl_dec = 7'b1000101; rt_src = 1'b1; end
      OP_LW:    ctrl_dec = 7'b1101001;
      OP_SW:    begin ctrl_dec = 7'b0011001; rt_src = 1'b1; end
      OP_BEQ:   begin ctrl_dec = 7'b0000011; rt_src = 1'b1; end
      OP_ADDI:  ctrl_dec = 7'b1001001;
      default:  ctrl_dec = 7'b0000000;
    endcase
  end

  // Load-use hazard: the load now in EX targets a register this instruction reads.
  always_comb begin
    STALL = ID_EX_CTRL[CTRL_MEMREAD] && ID_EX_CTRL[CTRL_VALID] && (ID_EX_RT != 5'd0) &&
            ((ID_EX_RT == rs) || (rt_src && (ID_EX_RT == rt)));
  end

  // A real instruction advances only when neither stalled nor flushed.
  assign load_p0 = ctrl_dec[CTRL_VALID] && !STALL && !EX_MEM_PCSrc;

  // ID/EX boundary: capture the decoded instruction or insert an all-zero bubble.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ID_EX_NPC   <= '0;
      ID_EX_A     <= '0;
      ID_EX_B     <= '0;
      ID_EX_IMM   <= '0;
      ID_EX_RT    <= '0;
      ID_EX_RD    <= '0;
      ID_EX_FUNCT <= '0;
      ID_EX_CTRL  <= '0;
    end else if (load_p0) begin
      ID_EX_NPC   <= IF_ID_NPC;
      ID_EX_A     <= a_rd;
      ID_EX_B     <= b_rd;
      ID_EX_IMM   <= sext16(IF_ID_INSTR[15:0]);
      ID_EX_RT    <= rt;
      ID_EX_RD    <= rd;
      ID_EX_FUNCT <= IF_ID_INSTR[5:0];
      ID_EX_CTRL  <= ctrl_dec;
    end else begin
      ID_EX_NPC   <= '0;
      ID_EX_A     <= '0;
      ID_EX_B     <= '0;
      ID_EX_IMM   <= '0;
      ID_EX_RT    <= '0;
      ID_EX_RD    <= '0;
      ID_EX_FUNCT <= '0;
      ID_EX_CTRL  <= '0;
    end
  end

endmodule

// File: tb/tb_i_decode.sv
// Scoreboard bench for i_decode: each directed step pushes its expected STALL
// (before the edge) and ID/EX contents (after the edge); a monitor pops them.
module tb_i_decode;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [31:0] IF_ID_INSTR = 32'hFC000000;
  logic [31:0] IF_ID_NPC = 32'h0;
  logic        EX_MEM_PCSrc = 1'b0;
  logic        MEM_WB_RegWrite = 1'b0;
  logic [4:0]  MEM_WB_WriteReg = 5'd0;
  logic [31:0] MEM_WB_WriteData = 32'h0;
  logic        STALL;
  logic [31:0] ID_EX_NPC, ID_EX_A, ID_EX_B, ID_EX_IMM;
  logic [4:0]  ID_EX_RT, ID_EX_RD;
  logic [5:0]  ID_EX_FUNCT;
  logic [6:0]  ID_EX_CTRL;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          id;
    logic        stall;
    logic [150:0] out;
  } exp_t;

  exp_t sb[$];

  localparam logic [31:0] NOP = 32'hFC000000;
`ifdef ID_WB_BYPASS_EN
  localparam logic [31:0] A16 = 32'h0000A5A5;
`else
  localparam logic [31:0] A16 = 32'h00001111;
`endif

  i_decode dut (
    .CLK(CLK), .RST(RST), .IF_ID_INSTR(IF_ID_INSTR), .IF_ID_NPC(IF_ID_NPC),
    .EX_MEM_PCSrc(EX_MEM_PCSrc), .MEM_WB_RegWrite(MEM_WB_RegWrite),
    .MEM_WB_WriteReg(MEM_WB_WriteReg), .MEM_WB_WriteData(MEM_WB_WriteData),
    .STALL(STALL), .ID_EX_NPC(ID_EX_NPC), .ID_EX_A(ID_EX_A), .ID_EX_B(ID_EX_B),
    .ID_EX_IMM(ID_EX_IMM), .ID_EX_RT(ID_EX_RT), .ID_EX_RD(ID_EX_RD),
    .ID_EX_FUNCT(ID_EX_FUNCT), .ID_EX_CTRL(ID_EX_CTRL)
  );

  always #5 CLK = ~CLK;

  function automatic logic [150:0] pack(input logic [6:0] c, input logic [31:0] n, a, b, i,
                                        input logic [4:0] t, d, input logic [5:0] f);
    pack = {c, n, a, b, i, t, d, f};
  endfunction

  task automatic check(input string name, input logic [150:0] got, input logic [150:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  // One directed step: drive inputs at negedge, queue expectations, wait for the edge.
  task automatic step(input int id, input logic [31:0] instr, npc, input logic pcsrc,
                      input logic we, input logic [4:0] wr, input logic [31:0] wd,
                      input logic [6:0] c, input logic [31:0] en, ea, eb, ei,
                      input logic [4:0] et, ed, input logic [5:0] ef, input logic es);
    exp_t e;
    @(negedge CLK);
    IF_ID_INSTR = instr; IF_ID_NPC = npc; EX_MEM_PCSrc = pcsrc;
    MEM_WB_RegWrite = we; MEM_WB_WriteReg = wr; MEM_WB_WriteData = wd;
    e.id = id; e.stall = es; e.out = pack(c, en, ea, eb, ei, et, ed, ef);
    sb.push_back(e);
    @(posedge CLK);
  endtask

  // Monitor: STALL checked mid-low-phase, ID/EX contents checked just after the edge.
  initial begin
    exp_t r;
    forever begin
      @(negedge CLK); #2;
      if (sb.size() > 0)
        check($sformatf("stall_step%0d", sb[0].id), {150'd0, STALL}, {150'd0, sb[0].stall});
      @(posedge CLK); #1;
      if (sb.size() > 0) begin
        r = sb.pop_front();
        check($sformatf("idex_step%0d", r.id),
              pack(ID_EX_CTRL, ID_EX_NPC, ID_EX_A, ID_EX_B, ID_EX_IMM, ID_EX_RT, ID_EX_RD, ID_EX_FUNCT),
              r.out);
      end
    end
  end

  initial begin
    int waitc;
    repeat (2) @(posedge CLK);
    #1;
    check("reset_idex", pack(ID_EX_CTRL, ID_EX_NPC, ID_EX_A, ID_EX_B, ID_EX_IMM, ID_EX_RT, ID_EX_RD, ID_EX_FUNCT), '0);
    check("reset_stall", {150'd0, STALL}, '0);
    @(negedge CLK); RST = 1'b0;

    //    id instr          npc          pc we wr  wd            ctrl   npc          A            B            IMM          RT RD FN    ST
    step( 1, NOP,          32'h0,       0, 1, 9,  32'd5,        7'h00, 32'h0,       32'h0,       32'h0,       32'h0,       0, 0, 6'h00, 0);
    step( 2, NOP,          32'h0,       0, 1, 13, 32'd7,        7'h00, 32'h0,       32'h0,       32'h0,       32'h0,       0, 0, 6'h00, 0);
    step( 3, 32'h012DB820, 32'h100,     0, 0, 0,  32'h0,        7'h45, 32'h100,     32'd5,       32'd7,       32'hFFFFB820,13,23,6'h20, 0);
    step( 4, 32'h2124FFFF, 32'h104,     0, 0, 0,  32'h0,        7'h49, 32'h104,     32'd5,       32'h0,       32'hFFFFFFFF,4, 31,6'h3F, 0);
    step( 5, 32'h20047FFF, 32'h108,     0, 0, 0,  32'h0,        7'h49, 32'h108,     32'h0,       32'h0,       32'h00007FFF,4, 15,6'h3F, 0);
    step( 6, 32'h8C080004, 32'h10C,     0, 0, 0,  32'h0,        7'h69, 32'h10C,     32'h0,       32'h0,       32'h4,       8, 0, 6'h04, 0);
    step( 7, 32'h01095020, 32'h110,     0, 0, 0,  32'h0,        7'h00, 32'h0,       32'h0,       32'h0,       32'h0,       0, 0, 6'h00, 1);
    step( 8, 32'h01095020, 32'h110,     0, 0, 0,  32'h0,        7'h45, 32'h110,     32'h0,       32'd5,       32'h00005020,9, 10,6'h20, 0);
    step( 9, 32'h8C080004, 32'h114,     0, 0, 0,  32'h0,        7'h69, 32'h114,     32'h0,       32'h0,       32'h4,       8, 0, 6'h04, 0);
    step(10, 32'h20080001, 32'h118,     0, 0, 0,  32'h0,        7'h49, 32'h118,     32'h0,       32'h0,       32'h1,       8, 0, 6'h01, 0);
    step(11, 32'h012DB820, 32'h11C,     1, 0, 0,  32'h0,        7'h00, 32'h0,       32'h0,       32'h0,       32'h0,       0, 0, 6'h00, 0);
    step(12, 32'h8C080004, 32'h200,     0, 0, 0,  32'h0,        7'h69, 32'h200,     32'h0,       32'h0,       32'h4,       8, 0, 6'h04, 0);
    step(13, 32'h01095020, 32'h204,     1, 0, 0,  32'h0,        7'h00, 32'h0,       32'h0,       32'h0,       32'h0,       0, 0, 6'h00, 1);
    step(14, 32'h01095020, 32'h204,     0, 0, 0,  32'h0,        7'h45, 32'h204,     32'h0,       32'd5,       32'h00005020,9, 10,6'h20, 0);
    step(15, NOP,          32'h0,       0, 1, 5,  32'h1111,     7'h00, 32'h0,       32'h0,       32'h0,       32'h0,       0, 0, 6'h00, 0);
    step(16, 32'h00A00820, 32'h208,     0, 1, 5,  32'hA5A5,     7'h45, 32'h208,     A16,         32'h0,       32'h00000820,0, 1, 6'h20, 0);
    step(17, 32'h00A00820, 32'h20C,     0, 1, 0,  32'hDEAD,     7'h45, 32'h20C,     32'hA5A5,    32'h0,       32'h00000820,0, 1, 6'h20, 0);
    step(18, 32'h00000820, 32'h210,     0, 0, 0,  32'h0,        7'h45, 32'h210,     32'h0,       32'h0,       32'h00000820,0, 1, 6'h20, 0);

    // Asynchronous reset mid-run, away from any clock edge.
    @(negedge CLK);
    IF_ID_INSTR = 32'h8C080004; MEM_WB_RegWrite = 1'b0; EX_MEM_PCSrc = 1'b0;
    #2 RST = 1'b1;
    #1;
    check("midrst_idex", pack(ID_EX_CTRL, ID_EX_NPC, ID_EX_A, ID_EX_B, ID_EX_IMM, ID_EX_RT, ID_EX_RD, ID_EX_FUNCT), '0);
    check("midrst_stall", {150'd0, STALL}, '0);
    @(negedge CLK); RST = 1'b0;

    step(19, 32'h012DB820, 32'h300,     0, 0, 0,  32'h0,        7'h45, 32'h300,     32'h0,       32'h0,       32'hFFFFB820,13,23,6'h20, 0);

    waitc = 0;
    while (sb.size() > 0 && waitc < 20) begin
      @(posedge CLK); #2;
      waitc++;
    end
    if (sb.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain pending=%0d required=0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
